// File: rtl/aux_osc_ctrl.sv
// Sequencer/measurement controller for the auxiliary ring oscillator: enable, settle, count edges, report.
// Optional macro AUX_OSC_CTRL_CONT_EN selects continuous back-to-back measurement windows.
module aux_osc_ctrl #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIN_W-1:0] win_len,
    input  logic             osc_in,
    output logic             glob_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1, r_sync2, r_sync3;
    logic [SC_W-1:0]  r_settle_cnt;
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_acc;
    logic             r_ovf_acc;
    logic             r_glob_en, r_busy, r_done, r_ovf;
    logic [CNT_W-1:0] r_count;

    logic             w_edge;
    logic             w_settle_last;
    logic             w_win_last;
    logic             w_acc_inc;
    logic             w_acc_full;
    logic [CNT_W-1:0] w_acc_nxt;
    logic             w_ovf_nxt;

    assign w_edge        = r_sync2 & ~r_sync3;
    assign w_settle_last = (r_settle_cnt == SC_W'(SETTLE_CYC - 1));
    assign w_win_last    = (r_win_cnt == WIN_W'(1));
    assign w_acc_inc     = (r_state == S_MEASURE) && w_edge;
    assign w_acc_full    = &r_acc;

    // An edge that arrives while the accumulator is already full is lost; flag it.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf_acc;
        if (w_acc_inc) begin
            if (w_acc_full) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_acc_nxt = r_acc + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_SETTLE;
            S_SETTLE:  if (w_settle_last) w_state_nxt = S_MEASURE;
            S_MEASURE: if (w_win_last) w_state_nxt = S_DONE;
            S_DONE: begin
`ifdef AUX_OSC_CTRL_CONT_EN
                w_state_nxt = S_MEASURE;
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default:   w_state_nxt = S_IDLE;
        endcase
        if (stop) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync3      <= 1'b0;
            r_settle_cnt <= '0;
            r_win        <= '0;
            r_win_cnt    <= '0;
            r_acc        <= '0;
            r_ovf_acc    <= 1'b0;
            r_glob_en    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_count      <= '0;
            r_ovf        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sync1 <= osc_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            // Outputs are decoded from the next state so they line up with the state register.
`ifdef AUX_OSC_CTRL_CONT_EN
            r_glob_en <= (w_state_nxt != S_IDLE);
`else
            r_glob_en <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);
`endif
            r_busy    <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_MEASURE);
            r_done    <= (w_state_nxt == S_DONE);

            if (r_state == S_IDLE && w_state_nxt == S_SETTLE) begin
                r_win        <= (win_len == '0) ? WIN_W'(1) : win_len;
                r_settle_cnt <= '0;
            end else if (r_state == S_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + SC_W'(1);
            end

            if (w_state_nxt == S_MEASURE && r_state != S_MEASURE) begin
                r_win_cnt <= r_win;
                r_acc     <= '0;
                r_ovf_acc <= 1'b0;
            end else if (r_state == S_MEASURE) begin
                r_win_cnt <= r_win_cnt - WIN_W'(1);
                r_acc     <= w_acc_nxt;
                r_ovf_acc <= w_ovf_nxt;
            end

            // Include the final window cycle's edge in the reported result.
            if (w_state_nxt == S_DONE) begin
                r_count <= w_acc_nxt;
                r_ovf   <= w_ovf_nxt;
            end
        end
    end

    assign glob_en   = r_glob_en;
    assign busy      = r_busy;
    assign done      = r_done;
    assign count     = r_count;
    assign ovf       = r_ovf;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_aux_osc_ctrl.sv
// Bench for aux_osc_ctrl: default-width and 4-bit-count instances share stimulus and are
// checked every cycle against a schedule/edge-count reference model.
module tb_aux_osc_ctrl;

    localparam int S = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] win_len = 16'd0;
    logic        osc_in = 1'b0;

    logic        glob_en, busy, done, ovf;
    logic [15:0] count;
    logic [1:0]  dbg_state;
    logic        glob_en4, busy4, done4, ovf4;
    logic [3:0]  count4;
    logic [1:0]  dbg_state4;

    aux_osc_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .win_len(win_len), .osc_in(osc_in),
        .glob_en(glob_en), .busy(busy), .done(done), .count(count), .ovf(ovf),
        .dbg_state(dbg_state)
    );

    aux_osc_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .win_len(win_len), .osc_in(osc_in),
        .glob_en(glob_en4), .busy(busy4), .done(done4), .count(count4), .ovf(ovf4),
        .dbg_state(dbg_state4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit osc_hist [0:65535];

    // Reference model: one accepted start time, its window, and the last reported results.
    bit m_run = 1'b0;
    int m_t = 0;
    int m_win = 1;
    int exp_cnt16 = 0;
    int exp_cnt4 = 0;
    bit exp_ovf16 = 1'b0;
    bit exp_ovf4 = 1'b0;
    int n_done = 0;

    int osc_mode = 0;
    int osc_per = 4;
    int osc_ph = 0;
    bit osc_force0 = 1'b0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    // 0 idle, 1 settle, 2 measure, 3 done for cycle n
    function automatic int phase(input int n);
        int rel;
        int r2;
        if (!m_run || n <= m_t) return 0;
        rel = n - m_t;
        if (rel <= S) return 1;
        r2 = rel - S - 1;
`ifdef AUX_OSC_CTRL_CONT_EN
        return ((r2 % (m_win + 1)) == m_win) ? 3 : 2;
`else
        if (r2 < m_win) return 2;
        if (r2 == m_win) return 3;
        return 0;
`endif
    endfunction

    // Rising edges of osc_in whose synchronized pulse lands inside the window ending before cycle d.
    function automatic int rises_for_done(input int d, input int w);
        int n = 0;
        for (int c = d - w - 2; c <= d - 3; c++) begin
            if (c >= 1 && osc_hist[c] && !osc_hist[c-1]) n++;
        end
        return n;
    endfunction

    task automatic step(input bit i_start, input bit i_stop, input int i_win, input bit i_rst);
        int ph;
        int e;
        bit v;
        bit exp_ge;
        @(posedge clk);
        cyc++;
        #1;
        if (chk_en) begin
            ph = phase(cyc);
            if (ph == 3) begin
                e = rises_for_done(cyc, m_win);
                exp_cnt16 = (e > 65535) ? 65535 : e;
                exp_ovf16 = (e > 65535);
                exp_cnt4  = (e > 15) ? 15 : e;
                exp_ovf4  = (e > 15);
            end
`ifdef AUX_OSC_CTRL_CONT_EN
            exp_ge = (ph != 0);
`else
            exp_ge = (ph == 1) || (ph == 2);
`endif
            if (done) n_done++;
            check_eq("glob_en", glob_en, exp_ge);
            check_eq("busy", busy, (ph == 1) || (ph == 2));
            check_eq("done", done, ph == 3);
            check_eq("count", count, exp_cnt16);
            check_eq("ovf", ovf, exp_ovf16);
            check_eq("glob_en4", glob_en4, exp_ge);
            check_eq("done4", done4, ph == 3);
            check_eq("count4", count4, exp_cnt4);
            check_eq("ovf4", ovf4, exp_ovf4);
        end
        if (osc_force0 || i_rst) v = 1'b0;
        else if (osc_mode == 1) v = ((osc_ph / osc_per) % 2) == 1;
        else if (osc_mode == 2) v = $urandom_range(0, 1) == 1;
        else v = 1'b0;
        osc_ph++;
        osc_in = v;
        osc_hist[cyc] = v;
        start = i_start;
        stop = i_stop;
        win_len = i_win[15:0];
        rst = i_rst;
        if (i_rst) begin
            m_run = 1'b0;
            exp_cnt16 = 0;
            exp_cnt4 = 0;
            exp_ovf16 = 1'b0;
            exp_ovf4 = 1'b0;
            chk_en = 1'b1;
        end else if (i_stop) begin
            m_run = 1'b0;
        end else if (i_start && phase(cyc) == 0) begin
            m_run = 1'b1;
            m_t = cyc;
            m_win = (i_win[15:0] == 16'd0) ? 1 : int'(i_win[15:0]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0, 1'b0);
    endtask

    // Runs until the model goes idle; a continuous loop is cut off with stop after a few windows.
    task automatic run_one(input int w);
        int budget;
        budget = S + 3 * (w + 1) + 6;
        step(1'b1, 1'b0, w, 1'b0);
        for (int i = 0; i < budget; i++) begin
            if (phase(cyc + 1) == 0) break;
            step(1'b0, 1'b0, 0, 1'b0);
        end
        if (phase(cyc + 1) != 0) step(1'b0, 1'b1, 0, 1'b0);
        idle(3);
    endtask

    initial begin
        osc_hist[0] = 1'b0;
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        idle(10);

        osc_mode = 1; osc_per = 4;
        run_one(80);
        osc_per = 2;
        run_one(200);
        osc_mode = 0;
        run_one(0);

        // Stop mid-measure, then a second run with a redundant start while busy.
        osc_mode = 1; osc_per = 3;
        step(1'b1, 1'b0, 50, 1'b0);
        idle(S + 10);
        step(1'b0, 1'b1, 0, 1'b0);
        idle(4);
        n_done = 0;
        step(1'b1, 1'b0, 30, 1'b0);
        idle(20);
        step(1'b1, 1'b0, 99, 1'b0);
        for (int i = 0; i < S + 40; i++) begin
            if (phase(cyc + 1) == 0) break;
            step(1'b0, 1'b0, 0, 1'b0);
        end
        if (phase(cyc + 1) != 0) step(1'b0, 1'b1, 0, 1'b0);
        idle(3);
`ifndef AUX_OSC_CTRL_CONT_EN
        check_eq("one_done", n_done, 1);
`endif

        // start and stop together while idle
        step(1'b1, 1'b1, 20, 1'b0);
        idle(5);

        for (int it = 0; it < 30; it++) begin
            int w;
            int budget;
            int r;
            osc_mode = $urandom_range(0, 2);
            osc_per = $urandom_range(1, 8);
            w = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 120);
            budget = S + 3 * (w + 1) + 6;
            step(1'b1, 1'b0, w, 1'b0);
            for (int i = 0; i < budget; i++) begin
                r = $urandom_range(0, 299);
                step(r < 4, r == 4, $urandom_range(0, 60), 1'b0);
            end
            step(1'b0, 1'b1, 0, 1'b0);
            idle(3);
        end

        // reset in the middle of a measurement
        osc_mode = 2;
        step(1'b1, 1'b0, 60, 1'b0);
        idle(S + 20);
        osc_force0 = 1'b1;
        idle(3);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        idle(3);
        osc_force0 = 1'b0;
        osc_mode = 1; osc_per = 1;
        run_one(25);
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/aux_osc_ctrl.md
Name: aux_osc_ctrl

Overview:
Sequencing and measurement controller for the 7-stage auxiliary ring oscillator in the low-frequency tracking loop. Drives the oscillator's global enable, waits a settle interval, then counts oscillator rising edges over a programmable reference-clock window and reports the count. It gates the oscillator off between measurements to save power, and it sits between loop firmware/control logic and the aux oscillator core.

Parameters:
CNT_W, 16, width of edge-count result
WIN_W, 16, width of measurement-window length
SETTLE_CYC, 64, clk cycles between enable assertion and start of counting (>=1)

Ports:
clk  input  1  reference clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to run one measurement
stop  input  1  abort; returns to IDLE, oscillator off
win_len  input  WIN_W  window length in clk cycles, sampled on accepted start
osc_in  input  1  oscillator tap (asynchronous to clk; pre-divided if needed)
glob_en  output  1  oscillator enable to ring core
busy  output  1  high in SETTLE or MEASURE
done  output  1  one-cycle pulse when result valid
count  output  CNT_W  edge count of last completed measurement
ovf  output  1  last measurement saturated

Behaviour:
- Clock port is clk; reset port is rst. Reset is synchronous and active-high. Reset values: state=IDLE, glob_en=0, busy=0, done=0, count=0, ovf=0, internal counters=0.
- osc_in passes through a 2-FF synchronizer, then a third flop for rising-edge detection (sync2 & ~sync3). The synchronizer runs every cycle; edges are counted only in MEASURE.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE: glob_en=0. If start=1 and stop=0, then latch win = (win_len==0 ? 1 : win_len), clear the settle counter, and go to SETTLE.
- SETTLE: glob_en=1, busy=1. Stays exactly SETTLE_CYC cycles, then goes to MEASURE with the accumulator cleared and the window counter loaded with win.
- MEASURE: glob_en=1, busy=1. Stays exactly win cycles.
  - Each cycle with a detected edge increments the accumulator.
  - At all-ones the accumulator saturates and a sticky ovf_acc flag is set.
- DONE: lasts one cycle. glob_en=0, busy=0, done=1, count<=accumulator, ovf<=ovf_acc. Next state is IDLE.
- Timing: start accepted at cycle T gives glob_en=1 from T+1. MEASURE covers T+1+SETTLE_CYC through T+SETTLE_CYC+win. done is high at T+1+SETTLE_CYC+win.
- start while busy or in DONE: ignored, with no queuing.
- stop (any state, highest priority after rst): next state IDLE, glob_en=0 the next cycle. No done pulse; count/ovf keep their previous values.
- start and stop in the same cycle while in IDLE: stop wins, so the FSM stays in IDLE.
- rst mid-operation: everything returns to reset values on the next edge, including count.
- count/ovf change only in DONE (or on rst). They are stable between done pulses.
- All outputs are registered.

Optional Feature:
Macro AUX_OSC_CTRL_CONT_EN.
- Defined: continuous mode. DONE returns to MEASURE instead of IDLE, with glob_en held at 1 and no resettling. It reuses the latched win, reloads the window counter and clears the accumulator. done pulses every win+1 cycles. Only stop or rst ends the loop; busy stays 1 except in the DONE cycles.
- Undefined: single-shot behaviour as above.

Test Plan:
- Reset, then idle 10 cycles -> glob_en=0, busy=0, done=0, count=0, ovf=0 throughout.
- Default params; osc_in driven clk-synchronous, period 8 clk (4 high/4 low); start at T with win_len=80 -> glob_en rises at T+1, done at T+145, count=10, ovf=0.
- CNT_W=4; osc_in period 4; win_len=200 -> count=15, ovf=1 on done.
- win_len=0, osc_in constant 0 -> MEASURE lasts 1 cycle, done at T+66, count=0.
- start, then stop during MEASURE, then a further start pulse while busy in a second run -> after stop, glob_en=0 next cycle, no done, count unchanged. In the second run, the extra start is ignored and exactly one done is produced.
- With AUX_OSC_CTRL_CONT_EN, win_len=40, osc_in period 8 -> done every 41 cycles with count=5 (±1 for window boundary phase). glob_en stays 1 until stop, then drops the next cycle.
